z80_mem_wr16_seq: RTL and testbench
===================================

Z80_MEM_WR16_SEQ -- requirements
Module: z80_mem_wr16_seq

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 0: max consecutive Tw states per write cycle; 0 means unlimited.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: one-cycle request to store data at addr; honoured only in IDLE.
REQ-005 SHALL have port addr, input, 16: target address nn; captured on accepted start.
REQ-006 SHALL have port data, input, 16: register pair value (low byte = C/E/L/SPL); captured on accepted start.
REQ-007 SHALL have port wait_n, input, 1: Z80 WAIT, active-low, sampled at the end of T2/Tw.
REQ-008 SHALL have port mreq_n, output, 1: memory request strobe, active-low.
REQ-009 SHALL have port wr_n, output, 1: write strobe, active-low.
REQ-010 SHALL have port bus_addr, output, 16: address bus.
REQ-011 SHALL have port bus_wdata, output, 8: data bus out.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse after both writes complete.
REQ-014 SHALL have port timeout, output, 1: one-cycle pulse on a WAIT_LIMIT overrun.
REQ-015 SHALL have ports z80fi_bus_waddr and z80fi_bus_waddr2 (16 each), and z80fi_bus_wdata and z80fi_bus_wdata2 (8 each), outputs: trace of the two writes, valid while done=1.

Function
REQ-016 SHALL implement states IDLE, T1, T2, TW, T3, FIN, with a 1-bit byte index (0 = first write, 1 = second write).
REQ-017 IDLE with start=1: SHALL latch addr and data, set the index to 0, and enter T1 next cycle; start is ignored in any other state.
REQ-018 T1: SHALL drive bus_addr = latched addr + index (16-bit, wraps FFFF->0000), bus_wdata = low byte (index 0) or high byte (index 1), mreq_n=0, wr_n=1.
REQ-019 T2: SHALL hold address and data, keep mreq_n=0, and drive wr_n=0; at end of cycle, wait_n=0 -> TW, else -> T3.
REQ-020 TW: SHALL hold all outputs as in T2; wait_n=0 -> stay in TW, else -> T3; each TW cycle increments a wait counter, which is cleared on entry to T1.
REQ-021 T3: SHALL hold mreq_n=0, wr_n=0, address and data; next state is T1 with index=1 if index=0, else FIN.
REQ-022 FIN: SHALL drive done=1, mreq_n=1, wr_n=1, trace outputs = {addr, addr+1, data[7:0], data[15:8]}, then return to IDLE.
REQ-023 Minimum latency: start accepted at cycle 0 SHALL give done=1 in cycle 7; each TW cycle adds exactly 1.
REQ-024 WAIT_LIMIT>0 and the wait counter reaching WAIT_LIMIT with wait_n still 0: SHALL pulse timeout, deassert strobes, and go to IDLE next cycle without done; trace outputs are not updated.
REQ-025 start=1 in FIN SHALL be ignored; a new request is honoured only once IDLE is re-entered.
REQ-026 IDLE: SHALL drive mreq_n=1, wr_n=1, and hold bus_addr and bus_wdata at their last values.
REQ-027 wr_n SHALL never be 0 while mreq_n is 1.
REQ-028 bus_addr and bus_wdata SHALL change only on entry to T1 within a request.

Reset
REQ-029 reset=1 SHALL force IDLE next edge regardless of state, aborting any write in progress with no done or timeout pulse.
REQ-030 After reset: mreq_n=1, wr_n=1, busy=0, done=0, timeout=0, bus_addr=0000, bus_wdata=00, wait counter=0, index=0, all trace outputs 0.
REQ-031 start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-032 addr=1234, data=ABCD, wait_n=1: writes CD@1234 (cycles 1-3) then AB@1235 (cycles 4-6); done in cycle 7; trace = {1234,1235,CD,AB}.
REQ-033 addr=FFFF, data=0102: writes 02@FFFF then 01@0000; trace waddr2=0000.
REQ-034 wait_n=0 for 2 cycles during the first T2: two TW cycles, done in cycle 9, address and data stable throughout.
REQ-035 WAIT_LIMIT=3, wait_n held 0: timeout pulse after 3 TW cycles, no done, IDLE next cycle, strobes high.
REQ-036 reset asserted during the second write's T2: IDLE next cycle, strobes high, no done; a following start at 5000/1122 completes normally.
REQ-037 start pulsed while busy: ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/z80_mem_wr16_seq.sv
// Z80 16-bit store sequencer: writes a register pair to nn (low byte) and nn+1 (high byte)
// as two back-to-back memory write machine cycles, with WAIT stretching and optional timeout.
module z80_mem_wr16_seq #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  input  logic        wait_n,
  output logic        mreq_n,
  output logic        wr_n,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] z80fi_bus_waddr,
  output logic [15:0] z80fi_bus_waddr2,
  output logic [7:0]  z80fi_bus_wdata,
  output logic [7:0]  z80fi_bus_wdata2
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_TW, S_T3, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic        idx_q, idx_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic [15:0] tr_waddr_q, tr_waddr_d;
  logic [15:0] tr_waddr2_q, tr_waddr2_d;
  logic [7:0]  tr_wdata_q, tr_wdata_d;
  logic [7:0]  tr_wdata2_q, tr_wdata2_d;

  logic [15:0] wait_cnt_inc;
  logic        limit_hit;

  // Saturating so a very long stall cannot wrap back under the limit.
  assign wait_cnt_inc = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 16'd1;
  assign limit_hit    = (WAIT_LIMIT != 0) && (32'(wait_cnt_inc) >= WAIT_LIMIT);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    data_d      = data_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = 1'b0;
    tr_waddr_d  = tr_waddr_q;
    tr_waddr2_d = tr_waddr2_q;
    tr_wdata_d  = tr_wdata_q;
    tr_wdata2_d = tr_wdata2_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = addr;
          data_d      = data;
          idx_d       = 1'b0;
          wait_cnt_d  = '0;
          bus_addr_d  = addr;
          bus_wdata_d = data[7:0];
          state_d     = S_T1;
        end
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = wait_n ? S_T3 : S_TW;
      S_TW: begin
        wait_cnt_d = wait_cnt_inc;
        if (wait_n) begin
          state_d = S_T3;
        end else if (limit_hit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_T3: begin
        if (!idx_q) begin
          idx_d       = 1'b1;
          wait_cnt_d  = '0;
          bus_addr_d  = addr_q + 16'd1;
          bus_wdata_d = data_q[15:8];
          state_d     = S_T1;
        end else begin
          tr_waddr_d  = addr_q;
          tr_waddr2_d = addr_q + 16'd1;
          tr_wdata_d  = data_q[7:0];
          tr_wdata2_d = data_q[15:8];
          state_d     = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      tr_waddr_q  <= '0;
      tr_waddr2_q <= '0;
      tr_wdata_q  <= '0;
      tr_wdata2_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      tr_waddr_q  <= tr_waddr_d;
      tr_waddr2_q <= tr_waddr2_d;
      tr_wdata_q  <= tr_wdata_d;
      tr_wdata2_q <= tr_wdata2_d;
    end
  end

  // Strobes decode straight from state, so wr_n low always implies mreq_n low.
  assign mreq_n = !(state_q inside {S_T1, S_T2, S_TW, S_T3});
  assign wr_n   = !(state_q inside {S_T2, S_TW, S_T3});
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_FIN);
  assign timeout = timeout_q;

  assign bus_addr         = bus_addr_q;
  assign bus_wdata        = bus_wdata_q;
  assign z80fi_bus_waddr  = tr_waddr_q;
  assign z80fi_bus_waddr2 = tr_waddr2_q;
  assign z80fi_bus_wdata  = tr_wdata_q;
  assign z80fi_bus_wdata2 = tr_wdata2_q;

endmodule

// File: tb/tb_z80_mem_wr16_seq.sv
// Scoreboard bench for z80_mem_wr16_seq: expected write beats and done/timeout events
// are queued at stimulus time and checked by an independent negedge monitor.
module tb_z80_mem_wr16_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data = '0;
  logic        wait_n = 1'b1;
  logic        mreq_n, wr_n, busy, done, timeout;
  logic [15:0] bus_addr, z80fi_bus_waddr, z80fi_bus_waddr2;
  logic [7:0]  bus_wdata, z80fi_bus_wdata, z80fi_bus_wdata2;

  z80_mem_wr16_seq #(.WAIT_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .data(data),
    .wait_n(wait_n), .mreq_n(mreq_n), .wr_n(wr_n), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .busy(busy), .done(done), .timeout(timeout),
    .z80fi_bus_waddr(z80fi_bus_waddr), .z80fi_bus_waddr2(z80fi_bus_waddr2),
    .z80fi_bus_wdata(z80fi_bus_wdata), .z80fi_bus_wdata2(z80fi_bus_wdata2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } beat_t;

  typedef struct {
    bit          is_to;
    int          cyc;
    logic [15:0] wa;
    logic [15:0] wa2;
    logic [7:0]  wd;
    logic [7:0]  wd2;
  } evt_t;

  beat_t beat_q[$];
  evt_t  evt_q[$];
  beat_t cur;
  bit    mon_en = 1'b0;
  logic  prev_wr_n = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      evt_t e;
      if (!wr_n) chk("wr_implies_mreq", 32'(mreq_n), 32'd0);
      if (!wr_n && prev_wr_n) begin
        if (beat_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got %0h@%0h expected none", bus_wdata, bus_addr);
          cur.a = bus_addr;
          cur.d = bus_wdata;
        end else begin
          cur = beat_q.pop_front();
        end
      end
      if (!wr_n) begin
        chk("bus_addr", 32'(bus_addr), 32'(cur.a));
        chk("bus_wdata", 32'(bus_wdata), 32'(cur.d));
      end
      if (done || timeout) begin
        if (evt_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got done=%0b timeout=%0b expected none", done, timeout);
        end else begin
          e = evt_q.pop_front();
          chk("evt_timeout", 32'(timeout), 32'(e.is_to));
          chk("evt_done", 32'(done), 32'(!e.is_to));
          chk("evt_cycle", 32'(cyc), 32'(e.cyc));
          if (!e.is_to) begin
            chk("trace_waddr", 32'(z80fi_bus_waddr), 32'(e.wa));
            chk("trace_waddr2", 32'(z80fi_bus_waddr2), 32'(e.wa2));
            chk("trace_wdata", 32'(z80fi_bus_wdata), 32'(e.wd));
            chk("trace_wdata2", 32'(z80fi_bus_wdata2), 32'(e.wd2));
          end else begin
            chk("to_mreq_n", 32'(mreq_n), 32'd1);
            chk("to_wr_n", 32'(wr_n), 32'd1);
            chk("to_busy", 32'(busy), 32'd0);
          end
        end
      end
      prev_wr_n = wr_n;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request; wait_n is held low in cycles n+ws .. n+ws+nw-1.
  task automatic run_req(input logic [15:0] a, input logic [15:0] d, input int ws,
                         input int nw, input bit to_exp, input int lat);
    int n;
    start = 1'b1;
    addr  = a;
    data  = d;
    n     = cyc;
    beat_q.push_back('{a, d[7:0]});
    if (!to_exp) begin
      beat_q.push_back('{a + 16'd1, d[15:8]});
      evt_q.push_back('{1'b0, n + lat, a, a + 16'd1, d[7:0], d[15:8]});
    end else begin
      evt_q.push_back('{1'b1, n + lat, 16'h0, 16'h0, 8'h0, 8'h0});
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      start  = 1'b0;
      wait_n = !(k >= ws && k < ws + nw);
    end
    wait_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_mreq_n", 32'(mreq_n), 32'd1);
    chk("rst_wr_n", 32'(wr_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_bus_addr", 32'(bus_addr), 32'h0);
    chk("rst_bus_wdata", 32'(bus_wdata), 32'h0);
    chk("rst_tr_waddr", 32'(z80fi_bus_waddr), 32'h0);
    chk("rst_tr_waddr2", 32'(z80fi_bus_waddr2), 32'h0);
    chk("rst_tr_wdata", 32'(z80fi_bus_wdata), 32'h0);
    chk("rst_tr_wdata2", 32'(z80fi_bus_wdata2), 32'h0);
    mon_en = 1'b1;

    run_req(16'h1234, 16'hABCD, 0, 0, 1'b0, 7);
    run_req(16'hFFFF, 16'h0102, 0, 0, 1'b0, 7);
    run_req(16'h2000, 16'h3344, 2, 2, 1'b0, 9);
    run_req(16'h6000, 16'h7788, 2, 4, 1'b1, 6);
    chk("idle_bus_addr_hold", 32'(bus_addr), 32'h6000);
    chk("idle_bus_wdata_hold", 32'(bus_wdata), 32'h88);

    // Reset during the second write's T2 (cycle n+5).
    start = 1'b1;
    addr  = 16'h3000;
    data  = 16'h99AA;
    n     = cyc;
    beat_q.push_back('{16'h3000, 8'hAA});
    beat_q.push_back('{16'h3001, 8'h99});
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("abort_in_t2_wr_n", 32'(wr_n), 32'd0);
    chk("abort_in_t2_addr", 32'(bus_addr), 32'h3001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_mreq_n", 32'(mreq_n), 32'd1);
    chk("abort_wr_n", 32'(wr_n), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    run_req(16'h5000, 16'h1122, 0, 0, 1'b0, 7);

    // start together with reset must be dropped.
    reset = 1'b1;
    start = 1'b1;
    addr  = 16'h7777;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("start_with_reset_busy", 32'(busy), 32'd0);
    repeat (3) tick();

    // Extra start pulses while busy (T3 of first write, and FIN) are ignored.
    start = 1'b1;
    addr  = 16'h4000;
    data  = 16'h5566;
    n     = cyc;
    beat_q.push_back('{16'h4000, 8'h66});
    beat_q.push_back('{16'h4001, 8'h55});
    evt_q.push_back('{1'b0, n + 7, 16'h4000, 16'h4001, 8'h66, 8'h55});
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1;
    addr  = 16'hAAAA;
    data  = 16'h1111;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    addr  = 16'hBBBB;
    data  = 16'h2222;
    tick();
    start = 1'b0;
    chk("after_fin_busy", 32'(busy), 32'd0);
    repeat (8) tick();

    chk("beats_all_seen", 32'(beat_q.size()), 32'd0);
    chk("events_all_seen", 32'(evt_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
